sort_engine: RTL and testbench

//   Iterative, handshaked successor to the combinational sort block.

---
 rtl/sort_pkg.sv | 40 ++++
 rtl/sort_cmp_swap.sv | 41 ++++
 rtl/sort_engine.sv | 155 +++++++++++++++
 tb/tb_sort_engine.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared state encoding and compare/packing helpers for the iterative sort engine.
package sort_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StSort = 2'd1;
    localparam state_t StDone = 2'd2;

    // Keys are widened to this width before comparison, so SIZE may be at most 64.
    localparam int unsigned CmpW = 65;

    function automatic logic [CmpW-1:0] sext(input logic [CmpW-1:0] raw,
                                             input int unsigned   width,
                                             input logic          fill);
        logic [CmpW-1:0] upper;
        upper = {CmpW{1'b1}} << width;
        if (fill) begin
            return raw | upper;
        end
        return raw & ~upper;
    endfunction

    function automatic logic cmp_gt(input logic [CmpW-1:0] a,
                                    input logic [CmpW-1:0] b,
                                    input logic            signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Element k of a packed set sits at the MSB end first.
    function automatic int unsigned field_msb(input int unsigned k,
                                              input int unsigned n,
                                              input int unsigned w);
        return (n - k) * w - 1;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange element: orders a key pair (with its indices) when enabled.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int unsigned SIZE   = 16,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned SIGNED = 0
) (
    input  logic [SIZE-1:0]  a_key_i,
    input  logic [SIZE-1:0]  b_key_i,
    input  logic [IDX_W-1:0] a_idx_i,
    input  logic [IDX_W-1:0] b_idx_i,
    input  logic             desc_i,
    input  logic             en_i,
    output logic [SIZE-1:0]  first_key_o,
    output logic [SIZE-1:0]  second_key_o,
    output logic [IDX_W-1:0] first_idx_o,
    output logic [IDX_W-1:0] second_idx_o,
    output logic             swapped_o
);

    localparam logic SignedMode = (SIGNED != 0);

    logic [CmpW-1:0] a_ext;
    logic [CmpW-1:0] b_ext;
    logic            a_gt_b;
    logic            b_gt_a;

    assign a_ext  = sext(CmpW'(a_key_i), SIZE, SignedMode & a_key_i[SIZE-1]);
    assign b_ext  = sext(CmpW'(b_key_i), SIZE, SignedMode & b_key_i[SIZE-1]);
    assign a_gt_b = cmp_gt(a_ext, b_ext, SignedMode);
    assign b_gt_a = cmp_gt(b_ext, a_ext, SignedMode);

    // Strict compares only: equal keys stay put, which keeps the sort stable.
    assign swapped_o    = en_i & (desc_i ? b_gt_a : a_gt_b);
    assign first_key_o  = swapped_o ? b_key_i : a_key_i;
    assign second_key_o = swapped_o ? a_key_i : b_key_i;
    assign first_idx_o  = swapped_o ? b_idx_i : a_idx_i;
    assign second_idx_o = swapped_o ? a_idx_i : b_idx_i;

endmodule

// File: rtl/sort_engine.sv
// Handshaked odd-even transposition sorter: one pass per clock, returns keys with source indices.
module sort_engine
    import sort_pkg::*;
#(
    parameter int unsigned NUM_VALS   = 5,
    parameter int unsigned SIZE       = 16,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned EARLY_EXIT = 0,
    localparam int unsigned IDX_W     = $clog2(NUM_VALS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_desc,
    input  logic [NUM_VALS*SIZE-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_VALS*SIZE-1:0]  out_data,
    output logic [NUM_VALS*IDX_W-1:0] out_idx,
    output logic                      busy
);

    localparam int unsigned NumPairs = NUM_VALS - 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   pass_q, pass_d;
    logic               desc_q, desc_d;
    logic               noswap_q, noswap_d;
    logic [SIZE-1:0]    key_q [NUM_VALS];
    logic [SIZE-1:0]    key_d [NUM_VALS];
    logic [IDX_W-1:0]   idx_q [NUM_VALS];
    logic [IDX_W-1:0]   idx_d [NUM_VALS];

    logic [SIZE-1:0]    pair_first_key  [NumPairs];
    logic [SIZE-1:0]    pair_second_key [NumPairs];
    logic [IDX_W-1:0]   pair_first_idx  [NumPairs];
    logic [IDX_W-1:0]   pair_second_idx [NumPairs];
    logic [NumPairs-1:0] pair_en;
    logic [NumPairs-1:0] pair_swap;
    logic               any_swap;

    logic [SIZE-1:0]    net_key [NUM_VALS];
    logic [IDX_W-1:0]   net_idx [NUM_VALS];

    for (genvar i = 0; i < NumPairs; i++) begin : g_pair
        localparam logic Odd = 1'(i % 2);

        assign pair_en[i] = (pass_q[0] == Odd);

        sort_cmp_swap #(
            .SIZE   (SIZE),
            .IDX_W  (IDX_W),
            .SIGNED (SIGNED)
        ) u_cmp_swap (
            .a_key_i      (key_q[i]),
            .b_key_i      (key_q[i+1]),
            .a_idx_i      (idx_q[i]),
            .b_idx_i      (idx_q[i+1]),
            .desc_i       (desc_q),
            .en_i         (pair_en[i]),
            .first_key_o  (pair_first_key[i]),
            .second_key_o (pair_second_key[i]),
            .first_idx_o  (pair_first_idx[i]),
            .second_idx_o (pair_second_idx[i]),
            .swapped_o    (pair_swap[i])
        );
    end

    // Enabled pairs never overlap, so each slot takes at most one pair's result.
    for (genvar k = 0; k < NUM_VALS; k++) begin : g_net
        if (k == 0) begin : g_head
            assign net_key[k] = pair_en[k] ? pair_first_key[k] : key_q[k];
            assign net_idx[k] = pair_en[k] ? pair_first_idx[k] : idx_q[k];
        end else if (k == NUM_VALS - 1) begin : g_tail
            assign net_key[k] = pair_en[k-1] ? pair_second_key[k-1] : key_q[k];
            assign net_idx[k] = pair_en[k-1] ? pair_second_idx[k-1] : idx_q[k];
        end else begin : g_mid
            assign net_key[k] = pair_en[k]   ? pair_first_key[k]    :
                                pair_en[k-1] ? pair_second_key[k-1] : key_q[k];
            assign net_idx[k] = pair_en[k]   ? pair_first_idx[k]    :
                                pair_en[k-1] ? pair_second_idx[k-1] : idx_q[k];
        end

        assign out_data[field_msb(k, NUM_VALS, SIZE) -: SIZE]  = key_q[k];
        assign out_idx[field_msb(k, NUM_VALS, IDX_W) -: IDX_W] = idx_q[k];
    end

    assign any_swap = |pair_swap;

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        desc_d   = desc_q;
        noswap_d = noswap_q;
        key_d    = key_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d  = StSort;
                    pass_d   = '0;
                    desc_d   = in_desc;
                    noswap_d = 1'b0;
                    for (int k = 0; k < NUM_VALS; k++) begin
                        key_d[k] = in_data[field_msb(k, NUM_VALS, SIZE) -: SIZE];
                        idx_d[k] = IDX_W'(k);
                    end
                end
            end
            StSort: begin
                key_d    = net_key;
                idx_d    = net_idx;
                pass_d   = pass_q + IDX_W'(1);
                noswap_d = ~any_swap;
                if (pass_q == IDX_W'(NUM_VALS - 1)) begin
                    state_d = StDone;
                end else if ((EARLY_EXIT != 0) && (pass_q != '0) && !any_swap && noswap_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pass_q   <= '0;
            desc_q   <= 1'b0;
            noswap_q <= 1'b0;
            for (int k = 0; k < NUM_VALS; k++) begin
                key_q[k] <= '0;
                idx_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            desc_q   <= desc_d;
            noswap_q <= noswap_d;
            key_q    <= key_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StSort);
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: three configurations checked every cycle against a behavioural model.
module tb_sort_engine;

    localparam int N    = 5;
    localparam int W    = 16;
    localparam int IW   = 3;
    localparam int NDUT = 3;   // 0: unsigned, 1: signed, 2: unsigned with early exit

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    logic [NDUT-1:0] in_valid  = '0;
    logic [NDUT-1:0] in_desc   = '0;
    logic [NDUT-1:0] out_ready = '0;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] out_valid;
    logic [NDUT-1:0] busy;
    logic [N*W-1:0]  in_data  [NDUT];
    logic [N*W-1:0]  out_data [NDUT];
    logic [N*IW-1:0] out_idx  [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sort_engine #(
            .NUM_VALS   (N),
            .SIZE       (W),
            .SIGNED     ((g == 1) ? 1 : 0),
            .EARLY_EXIT ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_desc   (in_desc[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_idx   (out_idx[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] key_at(input logic [N*W-1:0] v, input int k);
        return v[(N-k)*W-1 -: W];
    endfunction

    function automatic bit out_of_order(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input bit desc, input bit sgn);
        if (sgn) return desc ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
        return desc ? (a < b) : (a > b);
    endfunction

    // Stable insertion sort; returns keys and original positions in output packing.
    function automatic void model_sort(input logic [N*W-1:0] v, input bit desc, input bit sgn,
                                       output logic [N*W-1:0] od, output logic [N*IW-1:0] oi);
        logic [W-1:0] k [N];
        int ix [N];
        logic [W-1:0] tk;
        int ti;
        for (int i = 0; i < N; i++) begin
            k[i] = key_at(v, i);
            ix[i] = i;
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (!out_of_order(k[j-1], k[j], desc, sgn)) break;
                tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
                ti = ix[j]; ix[j] = ix[j-1]; ix[j-1] = ti;
            end
        end
        od = '0;
        oi = '0;
        for (int i = 0; i < N; i++) begin
            od[(N-i)*W-1 -: W]   = k[i];
            oi[(N-i)*IW-1 -: IW] = IW'(ix[i]);
        end
    endfunction

    // Cycles from accept to result when stopping after two consecutive swap-free passes.
    function automatic int ee_latency(input logic [N*W-1:0] v, input bit desc, input bit sgn);
        logic [W-1:0] k [N];
        logic [W-1:0] tk;
        int prev;
        int sw;
        prev = -1;
        for (int i = 0; i < N; i++) k[i] = key_at(v, i);
        for (int p = 0; p < N; p++) begin
            sw = 0;
            for (int i = p % 2; i + 1 < N; i += 2) begin
                if (out_of_order(k[i], k[i+1], desc, sgn)) begin
                    tk = k[i]; k[i] = k[i+1]; k[i+1] = tk;
                    sw++;
                end
            end
            if (p >= 1 && sw == 0 && prev == 0) return p + 1;
            prev = sw;
        end
        return N;
    endfunction

    int              m_phase [NDUT] = '{default: 0};   // 0 idle, 1 sorting, 2 result held
    int              m_cnt   [NDUT] = '{default: 0};
    bit              m_zero  [NDUT] = '{default: 1'b1};
    logic [N*W-1:0]  m_data  [NDUT];
    logic [N*IW-1:0] m_idx   [NDUT];

    always @(posedge clk) begin : model
        logic [N*W-1:0]  od;
        logic [N*IW-1:0] oi;
        int              lat;
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                m_phase[d] <= 0;
                m_cnt[d]   <= 0;
                m_zero[d]  <= 1'b1;
            end else if (m_phase[d] == 0) begin
                if (in_valid[d]) begin
                    model_sort(in_data[d], in_desc[d], d == 1, od, oi);
                    lat = (d == 2) ? ee_latency(in_data[d], in_desc[d], d == 1) : N;
                    m_data[d]  <= od;
                    m_idx[d]   <= oi;
                    m_cnt[d]   <= lat;
                    m_phase[d] <= 1;
                    m_zero[d]  <= 1'b0;
                end
            end else if (m_phase[d] == 1) begin
                m_cnt[d] <= m_cnt[d] - 1;
                if (m_cnt[d] == 1) m_phase[d] <= 2;
            end else if (out_ready[d]) begin
                m_phase[d] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("in_ready[%0d]", d), 80'(in_ready[d]), 80'(m_phase[d] == 0));
                check($sformatf("busy[%0d]", d), 80'(busy[d]), 80'(m_phase[d] == 1));
                check($sformatf("out_valid[%0d]", d), 80'(out_valid[d]), 80'(m_phase[d] == 2));
                if (m_phase[d] == 2) begin
                    check($sformatf("out_data[%0d]", d), out_data[d], m_data[d]);
                    check($sformatf("out_idx[%0d]", d), 80'(out_idx[d]), 80'(m_idx[d]));
                end else if (m_phase[d] == 0 && m_zero[d]) begin
                    check($sformatf("cleared data[%0d]", d), out_data[d], '0);
                    check($sformatf("cleared idx[%0d]", d), 80'(out_idx[d]), '0);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Called #1 after an edge with the engine idle; scrambles inputs after the accept edge.
    task automatic send(input int d, input bit desc, input logic [N*W-1:0] v);
        in_valid[d] = 1'b1;
        in_desc[d]  = desc;
        in_data[d]  = v;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_desc[d]  = ~desc;
        in_data[d]  = ~v;
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic run(input int d, input bit desc, input logic [N*W-1:0] v,
                       input logic [N*W-1:0] ed, input logic [N*IW-1:0] ei, input int el,
                       input string nm);
        int lat;
        check({nm, " ready"}, 80'(in_ready[d]), 80'(1));
        send(d, desc, v);
        wait_done(d, lat);
        check({nm, " latency"}, 80'(lat), 80'(el));
        check({nm, " data"}, out_data[d], ed);
        check({nm, " idx"}, 80'(out_idx[d]), 80'(ei));
        take(d);
        check({nm, " idle after take"}, 80'(in_ready[d]), 80'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N*W-1:0]  pd;
        logic [N*IW-1:0] pi;
        int lat;
        int first_t;
        int second_t;

        for (int d = 0; d < NDUT; d++) in_data[d] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset in_ready[%0d]", d), 80'(in_ready[d]), 80'(1));
            check($sformatf("reset out_valid[%0d]", d), 80'(out_valid[d]), 80'(0));
            check($sformatf("reset busy[%0d]", d), 80'(busy[d]), 80'(0));
            check($sformatf("reset out_data[%0d]", d), out_data[d], '0);
        end

        model_sort({16'd7, 16'd3, 16'd9, 16'd1, 16'd5}, 1'b0, 1'b0, pd, pi);
        check("model pin data", pd, {16'd1, 16'd3, 16'd5, 16'd7, 16'd9});
        check("model pin idx", 80'(pi), 80'({3'd3, 3'd1, 3'd4, 3'd0, 3'd2}));

        run(0, 1'b0, {16'd7, 16'd3, 16'd9, 16'd1, 16'd5},
            {16'd1, 16'd3, 16'd5, 16'd7, 16'd9}, {3'd3, 3'd1, 3'd4, 3'd0, 3'd2}, 5, "asc");
        run(0, 1'b1, {16'd7, 16'd3, 16'd9, 16'd1, 16'd5},
            {16'd9, 16'd7, 16'd5, 16'd3, 16'd1}, {3'd2, 3'd0, 3'd4, 3'd1, 3'd3}, 5, "desc");
        run(0, 1'b0, {16'd4, 16'd2, 16'd4, 16'd2, 16'd4},
            {16'd2, 16'd2, 16'd4, 16'd4, 16'd4}, {3'd1, 3'd3, 3'd0, 3'd2, 3'd4}, 5, "stable");
        run(1, 1'b0, {16'hFFFF, 16'h0001, 16'h8000, 16'h0000, 16'h7FFF},
            {16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFF},
            {3'd2, 3'd0, 3'd3, 3'd1, 3'd4}, 5, "signed");
        run(0, 1'b0, {16'hFFFF, 16'h0001, 16'h8000, 16'h0000, 16'h7FFF},
            {16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF},
            {3'd3, 3'd1, 3'd4, 3'd2, 3'd0}, 5, "unsigned");
        run(2, 1'b0, {16'd2, 16'd1, 16'd3, 16'd4, 16'd5},
            {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, {3'd1, 3'd0, 3'd2, 3'd3, 3'd4}, 3, "early3");

        // Early exit on sorted input, then hold the result under backpressure.
        send(2, 1'b0, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5});
        wait_done(2, lat);
        check("early2 latency", 80'(lat), 80'(2));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold data", out_data[2], {16'd1, 16'd2, 16'd3, 16'd4, 16'd5});
            check("hold idx", 80'(out_idx[2]), 80'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
            check("hold valid", 80'(out_valid[2]), 80'(1));
            check("hold in_ready", 80'(in_ready[2]), 80'(0));
        end
        take(2);
        check("release in_ready", 80'(in_ready[2]), 80'(1));
        check("release out_valid", 80'(out_valid[2]), 80'(0));

        // Reset while pass 2 is being computed.
        send(0, 1'b0, {16'd9, 16'd8, 16'd7, 16'd6, 16'd5});
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy before rst", 80'(busy[0]), 80'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst in_ready", 80'(in_ready[0]), 80'(1));
        check("rst out_valid", 80'(out_valid[0]), 80'(0));
        check("rst busy", 80'(busy[0]), 80'(0));
        check("rst out_data", out_data[0], '0);
        run(0, 1'b0, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
            {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 5, "post-rst");

        // Back-to-back: in_valid and out_ready held high.
        first_t = -1;
        second_t = -1;
        in_data[0]   = {16'd3, 16'd1, 16'd2, 16'd5, 16'd4};
        in_desc[0]   = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        for (int c = 1; c <= 30 && second_t < 0; c++) begin
            @(posedge clk); #1;
            if (out_valid[0]) begin
                if (first_t < 0) first_t = c;
                else second_t = c;
            end
        end
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("throughput first", 80'(first_t), 80'(N + 1));
        check("throughput period", 80'(second_t - first_t), 80'(N + 2));

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
